// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects for D/E/M, D-stage stall, mult/div busy counter.
// Latency: forwarding and stall are combinational; the busy counter is one registered stage.
// Backpressure: stall_D freezes PC and D (bubble into E) on an unready operand or a busy HI/LO unit.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       EXC_flush,
    input  logic [4:0] A1_D,
    input  logic [4:0] A2_D,
    input  logic [1:0] Tuse_rs_D,
    input  logic [1:0] Tuse_rt_D,
    input  logic       md_D,
    input  logic [4:0] A1_E,
    input  logic [4:0] A2_E,
    input  logic [1:0] Res_E,
    input  logic [1:0] Res_M,
    input  logic [1:0] Res_W,
    input  logic [4:0] A3_E,
    input  logic [4:0] A3_M,
    input  logic [4:0] A3_W,
    input  logic [4:0] A2_M,
    input  logic       md_start_E,
    input  logic       md_div_E,
    output logic       stall_D,
    output logic       busy,
    output logic [1:0] FwdRS_D,
    output logic [1:0] FwdRT_D,
    output logic [1:0] FwdRS_E,
    output logic [1:0] FwdRT_E,
    output logic       FwdRT_M
);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_ALU  = 2'b01;
    localparam logic [1:0] RES_DM   = 2'b10;
    localparam logic [1:0] RES_PC   = 2'b11;
    localparam logic [1:0] TUSE_NA  = 2'b11;

    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYC);

    // A stage supplies a register only if it writes a nonzero destination equal to the source.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] a3, input logic [1:0] res);
        return (src != 5'd0) && (src == a3) && (res != RES_NONE);
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    tnew_e, tnew_m;
    logic          rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic          ers_m, ers_w, ert_m, ert_w;
    logic          stall_rs, stall_rt, stall_md;

    assign rs_e  = hit(A1_D, A3_E, Res_E);
    assign rs_m  = hit(A1_D, A3_M, Res_M);
    assign rs_w  = hit(A1_D, A3_W, Res_W);
    assign rt_e  = hit(A2_D, A3_E, Res_E);
    assign rt_m  = hit(A2_D, A3_M, Res_M);
    assign rt_w  = hit(A2_D, A3_W, Res_W);
    assign ers_m = hit(A1_E, A3_M, Res_M);
    assign ers_w = hit(A1_E, A3_W, Res_W);
    assign ert_m = hit(A2_E, A3_M, Res_M);
    assign ert_w = hit(A2_E, A3_W, Res_W);

    // Cycles until each in-flight result is available; W always has its data.
    always_comb begin
        tnew_e = 2'd0;
        tnew_m = 2'd0;
        case (Res_E)
            RES_ALU: tnew_e = 2'd1;
            RES_DM:  tnew_e = 2'd2;
            default: tnew_e = 2'd0;
        endcase
        if (Res_M == RES_DM) tnew_m = 2'd1;
    end

    // Stall when an operand is needed before the producing stage can deliver it.
    always_comb begin
        stall_rs = (Tuse_rs_D != TUSE_NA) &&
                   ((rs_e && (Tuse_rs_D < tnew_e)) || (rs_m && (Tuse_rs_D < tnew_m)));
        stall_rt = (Tuse_rt_D != TUSE_NA) &&
                   ((rt_e && (Tuse_rt_D < tnew_e)) || (rt_m && (Tuse_rt_D < tnew_m)));
        stall_md = md_D && (busy || md_start_E);
        stall_D  = stall_rs || stall_rt || stall_md;
    end

    // D-stage selects: the youngest matching stage wins; if its data is not ready, use GRF and rely on the stall.
    always_comb begin
        FwdRS_D = 2'b00;
        FwdRT_D = 2'b00;
        if (rs_e)      FwdRS_D = (Res_E == RES_PC) ? 2'b11 : 2'b00;
        else if (rs_m) FwdRS_D = (Res_M != RES_DM) ? 2'b10 : 2'b00;
        else if (rs_w) FwdRS_D = 2'b01;
        if (rt_e)      FwdRT_D = (Res_E == RES_PC) ? 2'b11 : 2'b00;
        else if (rt_m) FwdRT_D = (Res_M != RES_DM) ? 2'b10 : 2'b00;
        else if (rt_w) FwdRT_D = 2'b01;
    end

    // E-stage and M-stage selects: M shadows W, a load still in M cannot be forwarded.
    always_comb begin
        FwdRS_E = 2'b00;
        FwdRT_E = 2'b00;
        if (ers_m)      FwdRS_E = (Res_M != RES_DM) ? 2'b10 : 2'b00;
        else if (ers_w) FwdRS_E = 2'b01;
        if (ert_m)      FwdRT_E = (Res_M != RES_DM) ? 2'b10 : 2'b00;
        else if (ert_w) FwdRT_E = 2'b01;
        FwdRT_M = hit(A2_M, A3_W, Res_W);
    end

    // Busy counter next state: a non-flushed start (re)loads, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start_E && !EXC_flush) cnt_d = md_div_E ? DIV_LD : MULT_LD;
        else if (cnt_q != '0)         cnt_d = cnt_q - 1'b1;
    end

    // Busy counter register; reset wins over a start.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign busy = (cnt_q != '0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected output vectors queued at drive time, compared mid-cycle.
// Latency: one check per cycle, sampled on the falling edge.
// Backpressure: none; the bench drives every cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       EXC_flush;
    logic [4:0] A1_D, A2_D, A1_E, A2_E, A3_E, A3_M, A3_W, A2_M;
    logic [1:0] Tuse_rs_D, Tuse_rt_D, Res_E, Res_M, Res_W;
    logic       md_D, md_start_E, md_div_E;
    logic       stall_D, busy, FwdRT_M;
    logic [1:0] FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];
    string       tag_q[$];

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .EXC_flush(EXC_flush),
        .A1_D(A1_D), .A2_D(A2_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D), .md_D(md_D),
        .A1_E(A1_E), .A2_E(A2_E), .Res_E(Res_E), .Res_M(Res_M), .Res_W(Res_W),
        .A3_E(A3_E), .A3_M(A3_M), .A3_W(A3_W), .A2_M(A2_M),
        .md_start_E(md_start_E), .md_div_E(md_div_E),
        .stall_D(stall_D), .busy(busy),
        .FwdRS_D(FwdRS_D), .FwdRT_D(FwdRT_D), .FwdRS_E(FwdRS_E), .FwdRT_E(FwdRT_E),
        .FwdRT_M(FwdRT_M)
    );

    always #5 clk = ~clk;

    // Output vector layout: {stall_D, busy, FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M}
    function automatic logic [10:0] ev(input logic st, input logic bz, input logic [1:0] rsd,
                                       input logic [1:0] rtd, input logic [1:0] rse,
                                       input logic [1:0] rte, input logic rtm);
        return {st, bz, rsd, rtd, rse, rte, rtm};
    endfunction

    task automatic check_val(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (stall,busy,rsD,rtD,rsE,rtE,rtM)", tag, obs, exp);
        end
    endtask

    task automatic clr();
        EXC_flush = 0; md_D = 0; md_start_E = 0; md_div_E = 0;
        A1_D = 0; A2_D = 0; A1_E = 0; A2_E = 0; A2_M = 0;
        A3_E = 0; A3_M = 0; A3_W = 0;
        Res_E = 0; Res_M = 0; Res_W = 0;
        Tuse_rs_D = 2'd3; Tuse_rt_D = 2'd3;
    endtask

    // Queue the expectation for the current inputs, compare mid-cycle, then advance one cycle.
    task automatic step(input string tag, input logic [10:0] exp);
        logic [10:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 11'h7ff, 11'h000);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val(t, {stall_D, busy, FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M}, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        clr();
        @(posedge clk); #1;
        step("reset_zero", 11'd0);
        // Reset beats a start on the same edge.
        md_start_E = 1; md_div_E = 1;
        step("reset_vs_start", 11'd0);
        reset = 0; clr();
        step("after_reset_idle", 11'd0);

        // lw $1 in E, D needs rs=1 at Tuse 1.
        Res_E = 2'b10; A3_E = 5'd1; A1_D = 5'd1; Tuse_rs_D = 2'd1;
        step("lw_in_E_stall", ev(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        Res_E = 0; A3_E = 0; Res_M = 2'b10; A3_M = 5'd1;
        step("lw_in_M_nostall", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        Res_M = 0; A3_M = 0; Res_W = 2'b10; A3_W = 5'd1;
        step("lw_in_W_fwd", ev(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 0));
        clr();
        Res_M = 2'b10; A3_M = 5'd7; A2_D = 5'd7; Tuse_rt_D = 2'd0;
        step("lw_in_M_tuse0_stall", ev(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        clr();
        Res_E = 2'b10; A3_E = 5'd7; A2_D = 5'd7; Tuse_rt_D = 2'd3;
        step("lw_in_E_unused", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // jal in E, beq on $31 at Tuse 0.
        clr();
        Res_E = 2'b11; A3_E = 5'd31; A1_D = 5'd31; Tuse_rs_D = 2'd0;
        step("jal_E_fwd_pc8", ev(0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 0));

        // ALU in E: Tuse 0 stalls, Tuse 1 does not and reads the GRF.
        clr();
        Res_E = 2'b01; A3_E = 5'd9; A2_D = 5'd9; Tuse_rt_D = 2'd0;
        step("alu_E_tuse0_stall", ev(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        Tuse_rt_D = 2'd1;
        step("alu_E_tuse1_nostall", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // ALU $5 in M and W: M wins, then W.
        clr();
        Res_M = 2'b01; A3_M = 5'd5; Res_W = 2'b01; A3_W = 5'd5;
        A2_E = 5'd5; A1_D = 5'd5; Tuse_rs_D = 2'd0; A2_M = 5'd5;
        step("m_over_w", ev(0, 0, 2'b10, 2'b00, 2'b00, 2'b10, 1));
        Res_M = 0; A3_M = 0;
        step("w_only", ev(0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 1));
        Res_W = 2'b00;
        step("w_res_none", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // Writes to $0 never forward or stall.
        clr();
        Res_E = 2'b10; Res_M = 2'b01; Res_W = 2'b01;
        Tuse_rs_D = 2'd0; Tuse_rt_D = 2'd0;
        step("reg0_no_match", 11'd0);

        // div: stall in the start cycle plus 10 busy cycles.
        clr();
        md_D = 1; md_start_E = 1; md_div_E = 1;
        step("div_start", ev(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        md_start_E = 0; md_div_E = 0;
        for (int i = 1; i <= 10; i++) step($sformatf("div_busy_%0d", i), ev(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("div_done", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // mult: 5 busy cycles.
        md_start_E = 1;
        step("mult_start", ev(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        md_start_E = 0;
        for (int i = 1; i <= 5; i++) step($sformatf("mult_busy_%0d", i), ev(1, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("mult_done", ev(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));

        // A flushed start never loads the counter.
        clr();
        md_start_E = 1; md_div_E = 1; EXC_flush = 1;
        step("flush_start", 11'd0);
        clr();
        step("flush_no_busy", 11'd0);

        // Reset during busy cycle 3 clears the counter on that edge.
        md_start_E = 1; md_div_E = 1;
        step("rst_div_start", 11'd0);
        md_start_E = 0; md_div_E = 0;
        step("rst_busy_1", ev(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        step("rst_busy_2", ev(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        reset = 1;
        step("rst_busy_3", ev(0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
        reset = 0;
        step("rst_cleared", 11'd0);

        if (exp_q.size() != 0) check_val("scoreboard_leftover", 11'(exp_q.size()), 11'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
